// File: rtl/seq_detector_pkg.sv
// Shared constants and the pattern-compare helper for the serial sequence detector.
// The helper is written for up to 16-bit patterns so the RTL and the bench can share one definition.
package seq_detector_pkg;

    localparam int          SEQ_LEN_DEF     = 4;
    localparam logic [3:0]  SEQ_PATTERN_DEF = 4'b0110;
    localparam int          SEQ_LEN_MAX     = 16;

    // True when the low `len` bits of hist equal the low `len` bits of pattern.
    function automatic logic seq_match(input logic [SEQ_LEN_MAX-1:0] hist,
                                       input logic [SEQ_LEN_MAX-1:0] pattern,
                                       input int                     len);
        logic [SEQ_LEN_MAX-1:0] mask;
        mask = '0;
        for (int i = 0; i < SEQ_LEN_MAX; i++) begin
            if (i < len) begin
                mask[i] = 1'b1;
            end
        end
        return (((hist ^ pattern) & mask) == '0);
    endfunction

endpackage

// File: rtl/seq_detector_match_counter.sv
// Saturating event counter with enable and asynchronous active-low clear.
module seq_match_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_detector.sv
// Serial pattern detector: shifts x into a history register and pulses z for one
// cycle whenever the newest LEN bits equal PATTERN, with a saturating match count.
module seq_detector
    import seq_detector_pkg::*;
#(
    parameter int             LEN     = SEQ_LEN_DEF,
    parameter logic [LEN-1:0] PATTERN = SEQ_PATTERN_DEF,
    parameter bit             OVERLAP = 1'b1,
    parameter int             CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x,
    output logic             z,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int              FILL_W   = $clog2(LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(LEN);

    logic [LEN-1:0]    hist_q;
    logic [LEN-1:0]    hist_d;
    logic [FILL_W-1:0] fill_q;
    logic [FILL_W-1:0] fill_d;
    logic [FILL_W-1:0] fill_inc;
    logic              z_q;
    logic              hit;

    always_comb begin
        hist_d   = {hist_q[LEN-2:0], x};
        fill_inc = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
        hit      = (fill_inc == FILL_FULL) &&
                   seq_match(SEQ_LEN_MAX'(hist_d), SEQ_LEN_MAX'(PATTERN), LEN);
        // Without overlap the bits of this match must not seed the next one.
        fill_d   = (hit && !OVERLAP) ? '0 : fill_inc;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q <= '0;
            fill_q <= '0;
            z_q    <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            z_q    <= hit;
        end
    end

    seq_match_counter #(
        .CNT_W (CNT_W)
    ) u_match_counter (
        .clk   (clk),
        .rst_n (rst),
        .en_i  (hit),
        .cnt_o (match_cnt)
    );

    assign z = z_q;

endmodule

// File: tb/tb_seq_detector.sv
// Directed bench for seq_detector: four parameterisations share one stimulus stream.
module tb_seq_detector;

    logic       clk;
    logic       rst;
    logic       x;

    logic       z_def, z_ov0, z_ones, z_c2;
    logic [7:0] cnt_def, cnt_ov0, cnt_ones;
    logic [1:0] cnt_c2;

    int tests_run;
    int tests_failed;

    seq_detector dut_def (
        .clk(clk), .rst(rst), .x(x), .z(z_def), .match_cnt(cnt_def)
    );

    seq_detector #(.OVERLAP(1'b0)) dut_ov0 (
        .clk(clk), .rst(rst), .x(x), .z(z_ov0), .match_cnt(cnt_ov0)
    );

    seq_detector #(.PATTERN(4'b1111), .OVERLAP(1'b1)) dut_ones (
        .clk(clk), .rst(rst), .x(x), .z(z_ones), .match_cnt(cnt_ones)
    );

    seq_detector #(.CNT_W(2)) dut_c2 (
        .clk(clk), .rst(rst), .x(x), .z(z_c2), .match_cnt(cnt_c2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one bit, let the next rising edge sample it, then settle 1 ns.
    task automatic drive_bit(input logic b);
        x = b;
        @(posedge clk);
        #1;
        $display("[TB] t=%0t x=%0b z_def=%0b z_ov0=%0b z_ones=%0b z_c2=%0b cnt_def=%0d cnt_c2=%0d",
                 $time, b, z_def, z_ov0, z_ones, z_c2, cnt_def, cnt_c2);
    endtask

    // Pulse reset low for 3 ns between clock edges.
    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b0;
        #3;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        tests_run++;
        if (z_def !== 1'b0 || z_ov0 !== 1'b0 || z_ones !== 1'b0 || z_c2 !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_z: got def=%0b ov0=%0b ones=%0b c2=%0b, want all 0",
                     z_def, z_ov0, z_ones, z_c2);
        end
        tests_run++;
        if (cnt_def !== 8'd0 || cnt_ov0 !== 8'd0 || cnt_ones !== 8'd0 || cnt_c2 !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_cnt: got def=%0d ov0=%0d ones=%0d c2=%0d, want all 0",
                     cnt_def, cnt_ov0, cnt_ones, cnt_c2);
        end
        #3;
        rst = 1'b1;
    endtask

    task automatic test_single_match();
        logic [3:0] stim  = 4'b0110;
        logic [3:0] exp_z = 4'b0001;
        for (int i = 3; i >= 0; i--) begin
            drive_bit(stim[i]);
            tests_run++;
            if (z_def !== exp_z[i]) begin
                tests_failed++;
                $display("FAIL single_z bit%0d: got %0b, want %0b", 4 - i, z_def, exp_z[i]);
            end
        end
        tests_run++;
        if (cnt_def !== 8'd1) begin
            tests_failed++;
            $display("FAIL single_cnt: got %0d, want 1", cnt_def);
        end
    endtask

    task automatic test_stream();
        logic [8:0] stim  = 9'b011010110;
        logic [8:0] exp_z = 9'b000100001;
        pulse_reset();
        for (int i = 8; i >= 0; i--) begin
            drive_bit(stim[i]);
            tests_run++;
            if (z_def !== exp_z[i]) begin
                tests_failed++;
                $display("FAIL stream_z bit%0d: got %0b, want %0b", 9 - i, z_def, exp_z[i]);
            end
        end
        tests_run++;
        if (cnt_def !== 8'd2) begin
            tests_failed++;
            $display("FAIL stream_cnt: got %0d, want 2", cnt_def);
        end
    endtask

    task automatic test_overlap();
        logic [6:0] stim    = 7'b0110110;
        logic [6:0] exp_ov1 = 7'b0001001;
        logic [6:0] exp_ov0 = 7'b0001000;
        pulse_reset();
        for (int i = 6; i >= 0; i--) begin
            drive_bit(stim[i]);
            tests_run++;
            if (z_def !== exp_ov1[i]) begin
                tests_failed++;
                $display("FAIL overlap1_z bit%0d: got %0b, want %0b", 7 - i, z_def, exp_ov1[i]);
            end
            tests_run++;
            if (z_ov0 !== exp_ov0[i]) begin
                tests_failed++;
                $display("FAIL overlap0_z bit%0d: got %0b, want %0b", 7 - i, z_ov0, exp_ov0[i]);
            end
        end
        tests_run++;
        if (cnt_def !== 8'd2) begin
            tests_failed++;
            $display("FAIL overlap1_cnt: got %0d, want 2", cnt_def);
        end
        tests_run++;
        if (cnt_ov0 !== 8'd1) begin
            tests_failed++;
            $display("FAIL overlap0_cnt: got %0d, want 1", cnt_ov0);
        end
    endtask

    task automatic test_async_reset();
        logic [2:0] pre = 3'b011;
        pulse_reset();
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b0);
        tests_run++;
        if (z_def !== 1'b1 || cnt_def !== 8'd1) begin
            tests_failed++;
            $display("FAIL async_setup: got z=%0b cnt=%0d, want z=1 cnt=1", z_def, cnt_def);
        end
        // Assert reset with z high, well away from any clock edge.
        #1;
        rst = 1'b0;
        #1;
        tests_run++;
        if (z_def !== 1'b0 || cnt_def !== 8'd0) begin
            tests_failed++;
            $display("FAIL async_clear: got z=%0b cnt=%0d, want z=0 cnt=0", z_def, cnt_def);
        end
        #2;
        rst = 1'b1;
        for (int i = 2; i >= 0; i--) begin
            drive_bit(pre[i]);
        end
        #1;
        rst = 1'b0;
        #3;
        rst = 1'b1;
        drive_bit(1'b0);
        tests_run++;
        if (z_def !== 1'b0 || cnt_def !== 8'd0) begin
            tests_failed++;
            $display("FAIL async_discard: got z=%0b cnt=%0d, want z=0 cnt=0", z_def, cnt_def);
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] exp_z = 7'b0001111;
        pulse_reset();
        for (int i = 6; i >= 0; i--) begin
            drive_bit(1'b1);
            tests_run++;
            if (z_ones !== exp_z[i]) begin
                tests_failed++;
                $display("FAIL b2b_z bit%0d: got %0b, want %0b", 7 - i, z_ones, exp_z[i]);
            end
        end
        tests_run++;
        if (cnt_ones !== 8'd4) begin
            tests_failed++;
            $display("FAIL b2b_cnt: got %0d, want 4", cnt_ones);
        end
    endtask

    task automatic test_saturation();
        logic [15:0] stim    = 16'b0110110110110110;
        logic [15:0] exp_z   = 16'b0001001001001001;
        logic [1:0]  exp_cnt = 2'd0;
        pulse_reset();
        for (int i = 15; i >= 0; i--) begin
            drive_bit(stim[i]);
            if (exp_z[i] && exp_cnt != 2'd3) begin
                exp_cnt = exp_cnt + 2'd1;
            end
            tests_run++;
            if (z_c2 !== exp_z[i]) begin
                tests_failed++;
                $display("FAIL sat_z bit%0d: got %0b, want %0b", 16 - i, z_c2, exp_z[i]);
            end
            tests_run++;
            if (cnt_c2 !== exp_cnt) begin
                tests_failed++;
                $display("FAIL sat_cnt bit%0d: got %0d, want %0d", 16 - i, cnt_c2, exp_cnt);
            end
        end
        tests_run++;
        if (cnt_def !== 8'd5) begin
            tests_failed++;
            $display("FAIL sat_wide_cnt: got %0d, want 5", cnt_def);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b0;
        x            = 1'b0;
        #1;
        test_reset();
        test_single_match();
        test_stream();
        test_overlap();
        test_async_reset();
        test_back_to_back();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded 20000 ns");
        $fatal(1);
    end

endmodule
